// File: rtl/update_dispatch_if.sv
// ---------------------------------------------------------------------------
// update_dispatch_if
//
// Bundles the stream-side signals of the update dispatcher:
//   src_q / src_empty / src_rdreq      show-ahead input streams, one slot of
//                                      W = KEY_WIDTH+MSG_WIDTH bits per source
//   lane_q / lane_empty / lane_rdreq   show-ahead per-lane FIFO heads
//   ext_fifo_data / ext_fifo_wrreq /   write port of the external transmit
//   ext_fifo_full                      FIFO for foreign keys
//
// Modports:
//   master : environment side (drives sources, pops lanes, reports ext full)
//   slave  : dispatcher side
// ---------------------------------------------------------------------------
interface update_dispatch_if #(
    parameter int NUM_SRC   = 2,
    parameter int NUM_LANES = 4,
    parameter int KEY_WIDTH = 32,
    parameter int MSG_WIDTH = 32
);
    localparam int W = KEY_WIDTH + MSG_WIDTH;

    logic [NUM_SRC*W-1:0]   src_q;
    logic [NUM_SRC-1:0]     src_empty;
    logic [NUM_SRC-1:0]     src_rdreq;

    logic [NUM_LANES*W-1:0] lane_q;
    logic [NUM_LANES-1:0]   lane_empty;
    logic [NUM_LANES-1:0]   lane_rdreq;

    logic [W-1:0]           ext_fifo_data;
    logic                   ext_fifo_wrreq;
    logic                   ext_fifo_full;

    modport master (
        output src_q, src_empty, lane_rdreq, ext_fifo_full,
        input  src_rdreq, lane_q, lane_empty, ext_fifo_data, ext_fifo_wrreq
    );

    modport slave (
        input  src_q, src_empty, lane_rdreq, ext_fifo_full,
        output src_rdreq, lane_q, lane_empty, ext_fifo_data, ext_fifo_wrreq
    );
endinterface

// File: rtl/update_dispatch.sv
// ---------------------------------------------------------------------------
// update_dispatch
//
// Merges NUM_SRC {key,msg} update streams into one round-robin arbitrated
// flow. Keys owned by this worker are routed to one of NUM_LANES show-ahead
// lane FIFOs; foreign keys are forwarded to the external transmit FIFO.
// A source is only popped when its target is guaranteed room, so the lane
// FIFOs can never overflow and the external FIFO is never written when full.
//
// Ports:
//   clk                   single clock, rising edge
//   reset                 synchronous, active-high
//   bus                   update_dispatch_if.slave (sources, lanes, ext FIFO)
//   log_2_num_workers_in  log2 of worker count, bits [4:0] used
//   shard_id              this worker's shard
//   idle                  registered: sources empty, stage empty, lanes empty
//
// Optional feature (macro DISPATCH_STATS_EN):
//   stats_clear           synchronous clear of all write counters
//   lane_stat_count       NUM_LANES x 32-bit per-lane write counters
//   ext_stat_count        32-bit external write counter
// ---------------------------------------------------------------------------
module update_dispatch #(
    parameter int NUM_SRC         = 2,
    parameter int NUM_LANES       = 4,
    parameter int LANE_FIFO_DEPTH = 16,
    parameter int KEY_WIDTH       = 32,
    parameter int MSG_WIDTH       = 32
) (
    input  logic        clk,
    input  logic        reset,
    update_dispatch_if.slave bus,
    input  logic [31:0] log_2_num_workers_in,
    input  logic [31:0] shard_id,
    output logic        idle
`ifdef DISPATCH_STATS_EN
    ,
    input  logic                    stats_clear,
    output logic [NUM_LANES*32-1:0] lane_stat_count,
    output logic [31:0]             ext_stat_count
`endif
);

    localparam int W      = KEY_WIDTH + MSG_WIDTH;
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int PTR_W  = $clog2(LANE_FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int RR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // -----------------------------------------------------------------------
    // Key classification
    // -----------------------------------------------------------------------
    logic [4:0]           shift;
    logic [KEY_WIDTH-1:0] own_mask;
    logic [KEY_WIDTH-1:0] shard_k;
    logic [26:0]          unused_log2_bits;

    assign shift            = log_2_num_workers_in[4:0];
    assign unused_log2_bits = log_2_num_workers_in[31:5];
    // Low 'shift' bits of the key select the worker.
    assign own_mask         = ~({KEY_WIDTH{1'b1}} << shift);
    assign shard_k          = KEY_WIDTH'(shard_id);

    function automatic logic [LANE_W-1:0] lane_of(input logic [KEY_WIDTH-1:0] key,
                                                  input logic [4:0] sh);
        if (NUM_LANES == 1) return '0;
        return LANE_W'(key >> sh);
    endfunction

    // -----------------------------------------------------------------------
    // State declarations
    // -----------------------------------------------------------------------
    logic              stage_valid;
    logic              stage_ext;
    logic [LANE_W-1:0] stage_lane;
    logic [W-1:0]      stage_data;
    logic [RR_W-1:0]   rr;

    logic [W-1:0]       lane_mem   [NUM_LANES][LANE_FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr     [NUM_LANES];
    logic [PTR_W-1:0]   rd_ptr     [NUM_LANES];
    logic [CNT_W-1:0]   lane_count [NUM_LANES];
    logic [NUM_LANES-1:0] lane_wr;
    logic [NUM_LANES-1:0] lane_rd;
    logic [NUM_LANES-1:0] lane_empty_w;
    logic [NUM_LANES-1:0] lane_room;
    logic                 ext_room;

    // -----------------------------------------------------------------------
    // Room checks: the staged entry has not landed yet, so it is counted
    // against its target as if it already had.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        lane_room = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            lane_room[l] = (int'(lane_count[l]) +
                            int'(stage_valid && !stage_ext && stage_lane == LANE_W'(l)))
                           < LANE_FIFO_DEPTH;
        end
    end

    assign ext_room = !bus.ext_fifo_full && !(stage_valid && stage_ext);

    // -----------------------------------------------------------------------
    // Per-source decode and eligibility
    // -----------------------------------------------------------------------
    logic [W-1:0]         src_entry [NUM_SRC];
    logic [KEY_WIDTH-1:0] src_key   [NUM_SRC];
    logic [LANE_W-1:0]    src_lane  [NUM_SRC];
    logic [NUM_SRC-1:0]   src_owned;
    logic [NUM_SRC-1:0]   src_eligible;

    always_comb begin
        src_owned    = '0;
        src_eligible = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_entry[i] = bus.src_q[i*W +: W];
            src_key[i]   = src_entry[i][W-1:MSG_WIDTH];
            src_lane[i]  = lane_of(src_key[i], shift);
            src_owned[i] = (shift == 5'd0) ||
                           ((src_key[i] & own_mask) == (shard_k & own_mask));
            if (src_owned[i])
                src_eligible[i] = !bus.src_empty[i] && lane_room[src_lane[i]];
            else
                src_eligible[i] = !bus.src_empty[i] && ext_room;
        end
    end

    // -----------------------------------------------------------------------
    // Round-robin arbitration: first eligible source at index >= rr, wrapping
    // -----------------------------------------------------------------------
    logic            grant_valid;
    logic [RR_W-1:0] grant_idx;
    int              arb_idx;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        arb_idx     = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            arb_idx = int'(rr) + k;
            if (arb_idx >= NUM_SRC) arb_idx = arb_idx - NUM_SRC;
            if (!grant_valid && src_eligible[arb_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = RR_W'(arb_idx);
            end
        end
        // No pops while reset is held; the popped entry would be discarded.
        if (reset) grant_valid = 1'b0;
    end

    always_comb begin
        bus.src_rdreq = '0;
        if (grant_valid) bus.src_rdreq[grant_idx] = 1'b1;
    end

    // -----------------------------------------------------------------------
    // Stage register and round-robin pointer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            stage_valid <= 1'b0;
            stage_ext   <= 1'b0;
            stage_lane  <= '0;
            stage_data  <= '0;
            rr          <= '0;
        end else begin
            stage_valid <= grant_valid;
            if (grant_valid) begin
                stage_ext  <= !src_owned[grant_idx];
                stage_lane <= src_lane[grant_idx];
                stage_data <= src_entry[grant_idx];
                rr         <= (grant_idx == RR_W'(NUM_SRC - 1)) ? '0 : grant_idx + RR_W'(1);
            end
        end
    end

    assign bus.ext_fifo_wrreq = stage_valid && stage_ext;
    assign bus.ext_fifo_data  = stage_data;

    // -----------------------------------------------------------------------
    // Lane FIFOs
    // -----------------------------------------------------------------------
    always_comb begin
        lane_wr      = '0;
        lane_rd      = '0;
        lane_empty_w = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            lane_wr[l]      = stage_valid && !stage_ext && stage_lane == LANE_W'(l);
            lane_empty_w[l] = (lane_count[l] == '0);
            lane_rd[l]      = bus.lane_rdreq[l] && !lane_empty_w[l];
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by the
    // counts, so stale contents are never observed and the array can map to
    // plain RAM.
    always_ff @(posedge clk) begin
        for (int l = 0; l < NUM_LANES; l++) begin
            if (lane_wr[l]) lane_mem[l][wr_ptr[l]] <= stage_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                wr_ptr[l]     <= '0;
                rd_ptr[l]     <= '0;
                lane_count[l] <= '0;
            end
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (lane_wr[l]) wr_ptr[l] <= wr_ptr[l] + PTR_W'(1);
                if (lane_rd[l]) rd_ptr[l] <= rd_ptr[l] + PTR_W'(1);
                case ({lane_wr[l], lane_rd[l]})
                    2'b10:   lane_count[l] <= lane_count[l] + CNT_W'(1);
                    2'b01:   lane_count[l] <= lane_count[l] - CNT_W'(1);
                    default: lane_count[l] <= lane_count[l];
                endcase
            end
        end
    end

    always_comb begin
        bus.lane_q = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (!lane_empty_w[l]) bus.lane_q[l*W +: W] = lane_mem[l][rd_ptr[l]];
        end
    end

    assign bus.lane_empty = lane_empty_w;

    // -----------------------------------------------------------------------
    // Idle flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) idle <= 1'b0;
        else       idle <= (&bus.src_empty) && !stage_valid && (&lane_empty_w);
    end

`ifdef DISPATCH_STATS_EN
    // -----------------------------------------------------------------------
    // Write counters; clear wins over a coincident write.
    // -----------------------------------------------------------------------
    logic [31:0] lane_stat [NUM_LANES];
    logic [31:0] ext_stat;

    always_ff @(posedge clk) begin
        if (reset || stats_clear) begin
            for (int l = 0; l < NUM_LANES; l++) lane_stat[l] <= '0;
            ext_stat <= '0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (lane_wr[l]) lane_stat[l] <= lane_stat[l] + 32'd1;
            end
            if (bus.ext_fifo_wrreq) ext_stat <= ext_stat + 32'd1;
        end
    end

    always_comb begin
        lane_stat_count = '0;
        for (int l = 0; l < NUM_LANES; l++) lane_stat_count[l*32 +: 32] = lane_stat[l];
    end

    assign ext_stat_count = ext_stat;
`endif

endmodule

// File: tb/tb_update_dispatch.sv
// ---------------------------------------------------------------------------
// tb_update_dispatch
//
// Directed bench for update_dispatch (NUM_SRC=2, NUM_LANES=4, depth 16,
// 32-bit key and msg). Sources are modelled as show-ahead queues; a monitor
// on the falling edge drives source heads, records grants, lane pops and
// external writes. Routing uses s=2, shard_id=1: owned when key[1:0]==1,
// lane = key[3:2].
// ---------------------------------------------------------------------------
module tb_update_dispatch;

    localparam int W = 64;

    logic        clk;
    logic        reset;
    logic [31:0] log2_workers;
    logic [31:0] shard;
    logic        idle;
`ifdef DISPATCH_STATS_EN
    logic         stats_clear;
    logic [127:0] lane_stat_count;
    logic [31:0]  ext_stat_count;
`endif

    update_dispatch_if #(.NUM_SRC(2), .NUM_LANES(4), .KEY_WIDTH(32), .MSG_WIDTH(32)) dif ();

    update_dispatch #(
        .NUM_SRC(2), .NUM_LANES(4), .LANE_FIFO_DEPTH(16), .KEY_WIDTH(32), .MSG_WIDTH(32)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .bus                  (dif),
        .log_2_num_workers_in (log2_workers),
        .shard_id             (shard),
        .idle                 (idle)
`ifdef DISPATCH_STATS_EN
        ,
        .stats_clear          (stats_clear),
        .lane_stat_count      (lane_stat_count),
        .ext_stat_count       (ext_stat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cycle = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Source model and observation logs
    logic [W-1:0] srcq     [2][$];
    logic [W-1:0] lane_log [4][$];
    logic [W-1:0] ext_log  [$];
    int           ext_cyc  [$];
    int           gnt_log  [$];
    int           gnt_cyc  [$];
    int           gnt_cnt  [2];
    int           lane_fall_cyc [4];
    logic [3:0]   prev_empty = 4'hF;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            dif.src_empty[i]     = (srcq[i].size() == 0);
            dif.src_q[i*W +: W]  = (srcq[i].size() == 0) ? '0 : srcq[i][0];
        end
        #1;
        check("rdreq_onehot0", 64'($onehot0(dif.src_rdreq)), 64'd1);
        for (int i = 0; i < 2; i++) begin
            if (dif.src_rdreq[i]) begin
                gnt_log.push_back(i);
                gnt_cyc.push_back(cycle);
                gnt_cnt[i]++;
                void'(srcq[i].pop_front());
            end
        end
        if (dif.ext_fifo_wrreq) begin
            ext_log.push_back(dif.ext_fifo_data);
            ext_cyc.push_back(cycle);
        end
        for (int l = 0; l < 4; l++) begin
            if (dif.lane_rdreq[l] && !dif.lane_empty[l]) lane_log[l].push_back(dif.lane_q[l*W +: W]);
            if (!dif.lane_empty[l] && prev_empty[l]) lane_fall_cyc[l] = cycle;
            prev_empty[l] = dif.lane_empty[l];
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        gnt_cyc.delete();
        ext_log.delete();
        ext_cyc.delete();
        gnt_cnt[0] = 0;
        gnt_cnt[1] = 0;
        for (int l = 0; l < 4; l++) begin
            lane_log[l].delete();
            lane_fall_cyc[l] = -1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        dif.lane_rdreq    = '0;
        dif.ext_fifo_full = 1'b0;
        srcq[0].delete();
        srcq[1].delete();
        cyc(2);
        reset = 1'b0;
        cyc(1);
        clear_logs();
    endtask

    function automatic int order_errs(input int l);
        int e = 0;
        for (int k = 0; k < lane_log[l].size(); k++)
            if (lane_log[l][k][31:0] != 32'(k)) e++;
        return e;
    endfunction

    int alt_err;

    initial begin
        reset             = 1'b1;
        log2_workers      = 32'd2;
        shard             = 32'd1;
        dif.lane_rdreq    = '0;
        dif.ext_fifo_full = 1'b0;
        dif.src_empty     = '1;
        dif.src_q         = '0;
`ifdef DISPATCH_STATS_EN
        stats_clear       = 1'b0;
`endif
        clear_logs();

        // ---- Reset state, with a non-empty source held off by reset ----
        srcq[0].push_back({32'h5, 32'h1});
        cyc(3);
        check("rst_rdreq",      64'(dif.src_rdreq),      64'd0);
        check("rst_lane_empty", 64'(dif.lane_empty),     64'hF);
        check("rst_lane_q",     64'(dif.lane_q != '0),   64'd0);
        check("rst_ext_wrreq",  64'(dif.ext_fifo_wrreq), 64'd0);
        check("rst_ext_data",   dif.ext_fifo_data,       64'd0);
        check("rst_idle",       64'(idle),               64'd0);

        // ---- Idle and routing ----
        do_reset();
        cyc(2);
        check("idle_drained", 64'(idle), 64'd1);
        srcq[0].push_back({32'h5, 32'hA1});
        srcq[0].push_back({32'hD, 32'hA2});
        srcq[0].push_back({32'h6, 32'hA3});
        check("idle_hold", 64'(idle), 64'd1);
        cyc(1);
        check("idle_break", 64'(idle), 64'd0);
        cyc(6);
        check("route_grants", 64'(gnt_log.size()), 64'd3);
        check("route_lane_empty", 64'(dif.lane_empty), 64'b0101);
        check("route_lane1_q", dif.lane_q[1*W +: W], {32'h5, 32'hA1});
        check("route_lane3_q", dif.lane_q[3*W +: W], {32'hD, 32'hA2});
        check("route_ext_cnt", 64'(ext_log.size()), 64'd1);
        check("route_ext_data", ext_log[0], {32'h6, 32'hA3});
        check("route_lane1_lat", 64'(lane_fall_cyc[1] - gnt_cyc[0]), 64'd2);
        check("route_ext_lat", 64'(ext_cyc[0] - gnt_cyc[2]), 64'd1);

        // ---- Round-robin, both sources busy, distinct lanes ----
        do_reset();
        dif.lane_rdreq = 4'hF;
        for (int k = 0; k < 50; k++) begin
            srcq[0].push_back({32'h1, 32'(k)});
            srcq[1].push_back({32'h5, 32'(k)});
        end
        cyc(100);
        check("rr_total", 64'(gnt_log.size()), 64'd100);
        check("rr_src0", 64'(gnt_cnt[0]), 64'd50);
        check("rr_src1", 64'(gnt_cnt[1]), 64'd50);
        check("rr_g0", 64'(gnt_log[0]), 64'd0);
        check("rr_g1", 64'(gnt_log[1]), 64'd1);
        check("rr_g2", 64'(gnt_log[2]), 64'd0);
        check("rr_g3", 64'(gnt_log[3]), 64'd1);
        alt_err = 0;
        for (int k = 0; k < gnt_log.size(); k++) if (gnt_log[k] != (k % 2)) alt_err++;
        check("rr_alternation", 64'(alt_err), 64'd0);
        cyc(10);
        check("rr_lane0_cnt", 64'(lane_log[0].size()), 64'd50);
        check("rr_lane1_cnt", 64'(lane_log[1].size()), 64'd50);
        check("rr_lane0_order", 64'(order_errs(0)), 64'd0);
        check("rr_lane1_order", 64'(order_errs(1)), 64'd0);
        check("rr_idle", 64'(idle), 64'd1);

        // ---- Lane full back-pressure ----
        do_reset();
        for (int k = 0; k < 18; k++) srcq[0].push_back({32'h9, 32'(k)});
        for (int k = 0; k < 10; k++) srcq[1].push_back({32'h1, 32'(k)});
        cyc(40);
        check("full_src0_gnts", 64'(gnt_cnt[0]), 64'd16);
        check("full_src1_gnts", 64'(gnt_cnt[1]), 64'd10);
        check("full_src0_left", 64'(srcq[0].size()), 64'd2);
        check("full_rdreq", 64'(dif.src_rdreq), 64'd0);
        dif.lane_rdreq[2] = 1'b1;
        cyc(1);
        dif.lane_rdreq[2] = 1'b0;
        cyc(6);
        check("full_one_more", 64'(gnt_cnt[0]), 64'd17);
        check("full_src0_left2", 64'(srcq[0].size()), 64'd1);
        dif.lane_rdreq[2] = 1'b1;
        cyc(30);
        check("full_lane2_cnt", 64'(lane_log[2].size()), 64'd18);
        check("full_lane2_order", 64'(order_errs(2)), 64'd0);

        // ---- External FIFO full ----
        do_reset();
        dif.ext_fifo_full = 1'b1;
        srcq[0].push_back({32'h2, 32'h0});
        srcq[0].push_back({32'h3, 32'h1});
        cyc(5);
        check("extfull_gnts", 64'(gnt_cnt[0]), 64'd0);
        check("extfull_rdreq", 64'(dif.src_rdreq), 64'd0);
        dif.ext_fifo_full = 1'b0;
        cyc(6);
        check("ext_cnt", 64'(ext_log.size()), 64'd2);
        check("ext_first", ext_log[0], {32'h2, 32'h0});
        check("ext_second", ext_log[1], {32'h3, 32'h1});
        check("ext_lat", 64'(ext_cyc[0] - gnt_cyc[0]), 64'd1);

        // ---- Simultaneous write and pop at count 8 ----
        do_reset();
        for (int k = 0; k < 8; k++) srcq[0].push_back({32'h5, 32'(k)});
        cyc(12);
        srcq[0].push_back({32'h5, 32'd8});
        cyc(1);
        dif.lane_rdreq[1] = 1'b1;
        cyc(1);
        dif.lane_rdreq[1] = 1'b0;
        check("simul_pop_cnt", 64'(lane_log[1].size()), 64'd1);
        check("simul_pop_head", lane_log[1][0], {32'h5, 32'd0});
        for (int k = 9; k < 29; k++) srcq[0].push_back({32'h5, 32'(k)});
        cyc(40);
        check("simul_count8", 64'(srcq[0].size()), 64'd12);
        dif.lane_rdreq[1] = 1'b1;
        cyc(60);
        check("simul_total", 64'(lane_log[1].size()), 64'd29);
        check("simul_order", 64'(order_errs(1)), 64'd0);

        // ---- Reset mid-burst ----
        do_reset();
        for (int k = 0; k < 10; k++) srcq[0].push_back({32'hD, 32'(k)});
        cyc(4);
        check("mid_lane3_busy", 64'(dif.lane_empty[3]), 64'd0);
        reset = 1'b1;
        srcq[0].delete();
        cyc(1);
        check("mid_lane_empty", 64'(dif.lane_empty), 64'hF);
        check("mid_idle", 64'(idle), 64'd0);
        check("mid_ext_wrreq", 64'(dif.ext_fifo_wrreq), 64'd0);
        check("mid_lane_q", 64'(dif.lane_q != '0), 64'd0);
        reset = 1'b0;
        cyc(3);
        check("mid_idle_after", 64'(idle), 64'd1);

`ifdef DISPATCH_STATS_EN
        // ---- Write counters ----
        do_reset();
        dif.lane_rdreq = 4'hF;
        for (int k = 0; k < 10; k++) srcq[0].push_back({32'hD, 32'(k)});
        for (int k = 0; k < 4; k++)  srcq[1].push_back({32'h2, 32'(k)});
        cyc(30);
        check("stat_lane3", 64'(lane_stat_count[3*32 +: 32]), 64'd10);
        check("stat_lane0", 64'(lane_stat_count[0*32 +: 32]), 64'd0);
        check("stat_ext", 64'(ext_stat_count), 64'd4);
        stats_clear = 1'b1;
        cyc(1);
        stats_clear = 1'b0;
        check("stat_clr_lane3", 64'(lane_stat_count[3*32 +: 32]), 64'd0);
        check("stat_clr_ext", 64'(ext_stat_count), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
